// File: rtl/mac_dot_accum_if.sv
// Beat-in / group-result-out stream bundle for mac_dot_accum.
// The master side supplies beats and consumes results; the MAC is the slave.
interface mac_dot_accum_if #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32
);
  logic                            ivalid;
  logic                            iready;
  logic                            ilast;
  logic [NUM_LANES*DATA_WIDTH-1:0] dataa;
  logic [NUM_LANES*DATA_WIDTH-1:0] datab;
  logic                            ovalid;
  logic                            oready;
  logic [ACC_WIDTH-1:0]            result;
  logic                            overflow;

  modport master (
    output ivalid, ilast, dataa, datab, oready,
    input  iready, ovalid, result, overflow
  );

  modport slave (
    input  ivalid, ilast, dataa, datab, oready,
    output iready, ovalid, result, overflow
  );
endinterface

// File: rtl/mac_dot_accum.sv
// N-lane dot-product MAC: operand register, product register, pipelined adder
// tree and a group accumulator with optional saturation, behind valid/ready.
module mac_dot_accum #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter bit SIGNED     = 1'b1,
  parameter bit SATURATE   = 1'b1
) (
  input logic            clock,
  input logic            resetn,
  mac_dot_accum_if.slave bus
);
  localparam int LEVELS = $clog2(NUM_LANES);
  localparam int PW     = 2 * DATA_WIDTH;
  localparam int SW     = PW + LEVELS;
  localparam int NODES  = 2 * NUM_LANES;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX =
    SIGNED ? {1'b0, {(ACC_WIDTH-1){1'b1}}} : {ACC_WIDTH{1'b1}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN =
    SIGNED ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {ACC_WIDTH{1'b0}};

  logic stall;
  logic accept;

  logic                            op_valid;
  logic                            op_last;
  logic [NUM_LANES*DATA_WIDTH-1:0] op_a;
  logic [NUM_LANES*DATA_WIDTH-1:0] op_b;

  // Heap-ordered tree: leaves NUM_LANES..NODES-1 are the product stage,
  // node i sums nodes 2i and 2i+1, node 1 is the root of the last tree level.
  logic [SW-1:0] prod [NUM_LANES];
  logic [SW-1:0] node [1:NODES-1];
  logic [LEVELS:0] tag_valid;
  logic [LEVELS:0] tag_last;

  logic [ACC_WIDTH-1:0] acc;
  logic                 sticky;
  logic [ACC_WIDTH:0]   tree_ext;
  logic [ACC_WIDTH:0]   acc_ext;
  logic [ACC_WIDTH:0]   sum;
  logic                 acc_ovf;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 a_fire;
  logic                 a_last;

  logic [ACC_WIDTH-1:0] result_q;
  logic                 overflow_q;
  logic                 ovalid_q;

  assign stall        = ovalid_q && !bus.oready;
  assign accept       = bus.ivalid && !stall;
  assign bus.iready   = !stall;
  assign bus.ovalid   = ovalid_q;
  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;

  function automatic logic [PW-1:0] widen_op(input logic [DATA_WIDTH-1:0] x);
    return {{DATA_WIDTH{SIGNED && x[DATA_WIDTH-1]}}, x};
  endfunction

  function automatic logic [SW-1:0] widen_prod(input logic [PW-1:0] p);
    return {{LEVELS{SIGNED && p[PW-1]}}, p};
  endfunction

  // Low 2*DATA_WIDTH bits of a product of extended operands equal the exact
  // signed or unsigned product, so a single multiplier serves both modes.
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      prod[k] = widen_prod(widen_op(op_a[k*DATA_WIDTH +: DATA_WIDTH]) *
                           widen_op(op_b[k*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  // NOTE: data-path registers carry no reset; only the valid/last tags decide
  // whether their contents matter, so clearing them would buy nothing.
  always_ff @(posedge clock) begin
    if (!stall) begin
      op_a <= bus.dataa;
      op_b <= bus.datab;
      for (int k = 0; k < NUM_LANES; k++) begin
        node[NUM_LANES+k] <= prod[k];
      end
      // NOTE: non-blocking assignment makes every node read its children's
      // previous-cycle values, which is exactly one tree level per stage.
      for (int i = 1; i < NUM_LANES; i++) begin
        node[i] <= node[2*i] + node[2*i+1];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      op_valid  <= 1'b0;
      op_last   <= 1'b0;
      tag_valid <= '0;
      tag_last  <= '0;
    end else if (!stall) begin
      op_valid  <= accept;
      op_last   <= bus.ilast;
      tag_valid <= {tag_valid[LEVELS-1:0], op_valid};
      tag_last  <= {tag_last[LEVELS-1:0], op_last};
    end
  end

  assign a_fire = !stall && tag_valid[LEVELS];
  assign a_last = tag_last[LEVELS];

  // NOTE: every signal written here gets an unconditional value before any
  // branch, so no path leaves one holding its old value (no latch).
  always_comb begin
    tree_ext = {{(ACC_WIDTH+1-SW){SIGNED && node[1][SW-1]}}, node[1]};
    acc_ext  = {SIGNED && acc[ACC_WIDTH-1], acc};
    sum      = tree_ext + acc_ext;
    acc_ovf  = SIGNED ? (sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1]) : sum[ACC_WIDTH];
    acc_next = sum[ACC_WIDTH-1:0];
    if (acc_ovf && SATURATE) begin
      acc_next = (SIGNED && sum[ACC_WIDTH]) ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc        <= '0;
      sticky     <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      ovalid_q   <= 1'b0;
    end else if (!stall) begin
      // Not stalled means any held result is being taken this edge, so
      // ovalid only survives if a new group closes at the same time.
      ovalid_q <= a_fire && a_last;
      if (a_fire) begin
        if (a_last) begin
          result_q   <= acc_next;
          overflow_q <= sticky | acc_ovf;
          acc        <= '0;
          sticky     <= 1'b0;
        end else begin
          acc    <= acc_next;
          sticky <= sticky | acc_ovf;
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_dot_accum.sv
// Drives six differently configured MACs with identical beats; a scoreboard
// fed by an arithmetic reference model checks every accepted group result.
module tb_mac_dot_accum;
  localparam int NL   = 4;
  localparam int DW   = 8;
  localparam int NCFG = 6;
  localparam int CFG_ACCW [NCFG] = '{32, 32, 18, 18, 18, 18};
  localparam bit CFG_SGN  [NCFG] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam bit CFG_SAT  [NCFG] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  typedef struct {
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  logic ivalid = 1'b0;
  logic ilast  = 1'b0;
  logic oready = 1'b1;
  logic [NL*DW-1:0] dataa = '0;
  logic [NL*DW-1:0] datab = '0;

  logic        ov  [NCFG];
  logic        ir  [NCFG];
  logic        of  [NCFG];
  logic [31:0] res [NCFG];

  exp_t   exp_q [NCFG][$];
  longint acc_m [NCFG];
  bit     stk_m [NCFG];
  int     n_tests = 0;
  int     n_fail  = 0;
  bit     rand_done = 1'b0;

  always #5 clock = ~clock;

  for (genvar c = 0; c < NCFG; c++) begin : g_cfg
    mac_dot_accum_if #(.NUM_LANES(NL), .DATA_WIDTH(DW), .ACC_WIDTH(CFG_ACCW[c])) bus ();
    mac_dot_accum #(
      .NUM_LANES(NL), .DATA_WIDTH(DW), .ACC_WIDTH(CFG_ACCW[c]),
      .SIGNED(CFG_SGN[c]), .SATURATE(CFG_SAT[c])
    ) dut (
      .clock (clock),
      .resetn(resetn),
      .bus   (bus)
    );
    assign bus.ivalid = ivalid;
    assign bus.ilast  = ilast;
    assign bus.dataa  = dataa;
    assign bus.datab  = datab;
    assign bus.oready = oready;
    assign ov[c]      = bus.ovalid;
    assign ir[c]      = bus.iready;
    assign of[c]      = bus.overflow;
    assign res[c]     = 32'(bus.result);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic longint lane(input int c, input logic [DW-1:0] x);
    if (CFG_SGN[c]) return longint'($signed(x));
    return longint'(x);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCFG; c++) begin
      acc_m[c] = 0;
      stk_m[c] = 1'b0;
      exp_q[c].delete();
    end
  endfunction

  // Exact integer dot product, range test, then clamp or modular wrap.
  function automatic void model_beat(input logic [NL*DW-1:0] a, b, input logic last);
    for (int c = 0; c < NCFG; c++) begin
      longint dot, t, m, hi, lo;
      bit     o;
      exp_t   e;
      dot = 0;
      for (int k = 0; k < NL; k++) dot += lane(c, a[k*DW +: DW]) * lane(c, b[k*DW +: DW]);
      m = longint'(1) << CFG_ACCW[c];
      if (CFG_SGN[c]) begin hi = (m >> 1) - 1; lo = -(m >> 1); end
      else begin hi = m - 1; lo = 0; end
      t = acc_m[c] + dot;
      o = (t > hi) || (t < lo);
      if (o) begin
        if (CFG_SAT[c]) t = (t > hi) ? hi : lo;
        else begin
          t = t % m;
          if (t < 0) t += m;
          if (t > hi) t -= m;
        end
      end
      stk_m[c] = stk_m[c] | o;
      if (last) begin
        e.res = 32'(t & (m - 1));
        e.ovf = stk_m[c];
        exp_q[c].push_back(e);
        acc_m[c] = 0;
        stk_m[c] = 1'b0;
      end else begin
        acc_m[c] = t;
      end
    end
  endfunction

  function automatic bit pending();
    for (int c = 0; c < NCFG; c++) if (exp_q[c].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NL*DW-1:0] fill(input logic [DW-1:0] x);
    return {NL{x}};
  endfunction

  function automatic logic [NL*DW-1:0] rand_word();
    logic [NL*DW-1:0] w;
    for (int k = 0; k < NL; k++) begin
      case ($urandom_range(3))
        0:       w[k*DW +: DW] = 8'h80;
        1:       w[k*DW +: DW] = 8'h7F;
        2:       w[k*DW +: DW] = 8'hFF;
        default: w[k*DW +: DW] = DW'($urandom);
      endcase
    end
    return w;
  endfunction

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_beat(input logic [NL*DW-1:0] a, b, input logic last);
    int   waited = 0;
    logic fire;
    ivalid = 1'b1; dataa = a; datab = b; ilast = last;
    while (1) begin
      #1 fire = ir[0];
      @(posedge clock);
      if (fire) break;
      @(negedge clock);
      waited++;
      if (waited > 300) begin
        check("send_beat accept", 0, 1);
        ivalid = 1'b0;
        return;
      end
    end
    model_beat(a, b, last);
    @(negedge clock);
    ivalid = 1'b0; ilast = 1'b0;
  endtask

  task automatic wait_ovalid(input int budget);
    int n = 0;
    #3;
    while (!ov[0]) begin
      @(negedge clock); #3;
      n++;
      if (n > budget) begin
        check("ovalid wait", 0, 1);
        return;
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (pending() && n < 300) begin
      @(negedge clock);
      n++;
    end
    check("drain outstanding results", longint'(pending()), 0);
    repeat (2) @(negedge clock);
  endtask

  // Monitor: results are compared in the cycle they are handed over.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock); #2;
      if (resetn && oready) begin
        for (int c = 0; c < NCFG; c++) begin
          if (ov[c]) begin
            if (exp_q[c].size() == 0) begin
              check($sformatf("cfg%0d unexpected ovalid", c), ov[c], 0);
            end else begin
              e = exp_q[c].pop_front();
              check($sformatf("cfg%0d result", c), res[c], e.res);
              check($sformatf("cfg%0d overflow", c), of[c], e.ovf);
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clock);
    #3;
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("cfg%0d reset ovalid", c), ov[c], 0);
      check($sformatf("cfg%0d reset result", c), res[c], 0);
      check($sformatf("cfg%0d reset overflow", c), of[c], 0);
    end
    @(negedge clock);
    resetn = 1'b1;
    #1;
    for (int c = 0; c < NCFG; c++) check($sformatf("cfg%0d iready after reset", c), ir[c], 1);

    // Single beat of ones: result 4 exactly LAT=4 edges after acceptance.
    @(negedge clock);
    send_beat(fill(8'd1), fill(8'd1), 1'b1);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) @(negedge clock);
      #3;
      check($sformatf("latency ovalid at T+%0d", k), ov[0], (k == 4) ? 1 : 0);
    end
    @(negedge clock);
    drain();

    // Extreme operands, single-beat groups at full rate.
    send_beat(fill(8'h80), fill(8'h80), 1'b1);
    send_beat(fill(8'h80), fill(8'h7F), 1'b1);
    send_beat(fill(8'hFF), fill(8'hFF), 1'b1);
    drain();

    // Three-beat group followed immediately by a single-beat group.
    send_beat(fill(8'd1), fill(8'd1), 1'b0);
    send_beat(fill(8'd2), fill(8'd1), 1'b0);
    send_beat(fill(8'd3), fill(8'd1), 1'b1);
    send_beat(fill(8'd1), fill(8'd1), 1'b1);
    wait_ovalid(10);
    @(negedge clock); #3;
    check("back-to-back second ovalid", ov[0], 1);
    @(negedge clock); #3;
    check("back-to-back ovalid drop", ov[0], 0);
    @(negedge clock);
    drain();

    // Backpressure: results held and pipeline frozen while oready is low.
    oready = 1'b0;
    fork
      begin
        send_beat(rand_word(), rand_word(), 1'b1);
        send_beat(rand_word(), rand_word(), 1'b1);
        send_beat(rand_word(), rand_word(), 1'b0);
        send_beat(rand_word(), rand_word(), 1'b1);
        send_beat(rand_word(), rand_word(), 1'b1);
      end
      begin
        wait_ovalid(20);
        repeat (10) begin
          @(negedge clock); #3;
          for (int c = 0; c < NCFG; c++) begin
            check($sformatf("cfg%0d stall iready", c), ir[c], 0);
            check($sformatf("cfg%0d stall ovalid", c), ov[c], 1);
            if (exp_q[c].size() != 0)
              check($sformatf("cfg%0d stall result held", c), res[c], exp_q[c][0].res);
          end
        end
        @(negedge clock);
        oready = 1'b1;
      end
    join
    drain();

    // Overflow groups (saturate vs wrap), then a clean group.
    send_beat(fill(8'h80), fill(8'h80), 1'b0);
    send_beat(fill(8'h80), fill(8'h80), 1'b0);
    send_beat(fill(8'h80), fill(8'h80), 1'b1);
    send_beat(fill(8'd1), fill(8'd1), 1'b1);
    drain();

    // Asynchronous reset mid-group discards the partial sum.
    send_beat(fill(8'd1), fill(8'd1), 1'b0);
    send_beat(fill(8'd2), fill(8'd2), 1'b0);
    resetn = 1'b0;
    model_reset();
    #1;
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("cfg%0d async reset ovalid", c), ov[c], 0);
      check($sformatf("cfg%0d async reset result", c), res[c], 0);
      check($sformatf("cfg%0d async reset overflow", c), of[c], 0);
    end
    @(negedge clock);
    resetn = 1'b1;
    #1 check("iready after mid-group reset", ir[0], 1);
    @(negedge clock);
    send_beat(fill(8'd1), fill(8'd1), 1'b1);
    drain();

    // Randomized groups with bubbles and random backpressure.
    fork
      begin
        for (int i = 0; i < 240; i++) begin
          if ($urandom_range(4) == 0) begin
            ivalid = 1'b0;
            @(negedge clock);
          end
          send_beat(rand_word(), rand_word(), ($urandom_range(3) == 0) || (i == 239));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(negedge clock);
          oready = ($urandom_range(3) != 0);
        end
        oready = 1'b1;
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_dot_accum.md
Name: mac_dot_accum

Overview:
Parametrised successor to the fixed 4-lane 8-bit Cyclone V MAC (c5_mac_8bitx4). It computes an N-lane dot product per beat and accumulates beats into a group result.
- Pipelined multiply and adder tree feeding a running accumulator.
- Streaming valid/ready handshake on input and output.
- Configurable signedness, accumulator width, and saturate/wrap mode.
- Sits in a PE between the operand-fetch buffers and the output drain path.

Parameters:
NUM_LANES, 4, operand pairs per beat; power of two, 2..16.
DATA_WIDTH, 8, bits per operand.
ACC_WIDTH, 32, accumulator/result width; must be >= 2*DATA_WIDTH+log2(NUM_LANES).
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.
SATURATE, 1, 1 = clamp accumulator on overflow, 0 = wrap.

Ports:
clock  in  1  single clock; all state on rising edge.
resetn  in  1  asynchronous, active-low reset.
ivalid  in  1  input beat valid.
iready  out  1  block can accept a beat this cycle.
ilast  in  1  beat closes the current accumulation group.
dataa  in  NUM_LANES*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH].
datab  in  NUM_LANES*DATA_WIDTH  same packing as dataa.
ovalid  out  1  result valid.
oready  in  1  downstream accepts result.
result  out  ACC_WIDTH  group dot-product sum.
overflow  out  1  group saw at least one overflow; qualified by ovalid.

Behaviour:
- Beat accepted when ivalid && iready.
- Stall condition: stall = ovalid && !oready.
  - iready = !stall.
  - During stall, every pipeline register, valid bit and the accumulator hold their values.
- Pipeline, with LAT = 2 + log2(NUM_LANES):
  - Stage P: registers NUM_LANES products, each 2*DATA_WIDTH wide, signed or unsigned per SIGNED.
  - Stages T1..Tlog2N: one adder-tree level per stage, +1 bit width per level.
  - Stage A: accumulator.
  - A beat accepted at edge T makes its group result visible at edge T+LAT when it carries ilast, with no stall in between.
- Valid/last/overflow tags travel with the data through every stage.
- Accumulator arithmetic:
  - Tree sum is sign-extended (or zero-extended) and added to the accumulator at ACC_WIDTH+1 bits.
  - Overflow = result outside the ACC_WIDTH range (signed or unsigned per SIGNED).
  - SATURATE=1: clamp to max/min on overflow. SATURATE=0: keep the low ACC_WIDTH bits.
  - Sticky group overflow flag is set on any overflowing beat.
- Last beat:
  - result <= final accumulated value; overflow <= sticky flag, including the last beat's own overflow.
  - ovalid <= 1.
  - Accumulator and sticky flag clear to 0 in the same edge, so the next group starts from 0.
  - A following beat may enter Stage A the very next cycle.
- Non-last beats update the accumulator only; ovalid is unaffected.
- Output handshake:
  - ovalid stays high, and result/overflow stay stable, until oready.
  - On ovalid && oready with no new last beat arriving in Stage A, ovalid <= 0.
  - If a new last beat arrives in the same cycle, result reloads and ovalid stays 1 (back-to-back single-beat groups at full rate).
- Single-beat group (ivalid && ilast): result = that beat's dot product.
- Bubbles (ivalid low) inside a group are allowed; the accumulator holds.
- Reset (asynchronous assert, synchronous deassert is external):
  - All valid bits, accumulator, sticky flag, result, overflow and ovalid go to 0.
  - iready = 1 once resetn is high.
  - A partial group in flight is discarded.
- Simultaneous reset and handshake: reset wins.

Test Plan:
1. NUM_LANES=4, DW=8, SIGNED=1; one beat with all lanes a=1, b=1, ilast=1 at edge T -> ovalid=1 at T+4, result=4, overflow=0.
2. Single beat, all lanes a=-128, b=-128, ilast -> result=65536. Then a=-128, b=127 -> result=-65024. With SIGNED=0, a=b=0xFF -> result=260100.
3. Three-beat group with (a,b) all lanes = (1,1), (2,1), (3,1), ilast on the third, followed immediately by single beat (1,1,ilast) -> results 24 then 4, back-to-back on consecutive cycles with oready=1.
4. Backpressure:
   - Hold oready=0 after ovalid rises -> iready=0, result and all pipeline state frozen for 10 cycles.
   - Release oready -> held result accepted once, then the next queued group result appears with no loss or duplication.
5. ACC_WIDTH=18:
   - SATURATE=1: three beats of (-128,-128) with ilast on the third -> result=131071, overflow=1.
   - SATURATE=0, same stimulus -> result=-65536 (wrap), overflow=1.
   - Next clean group -> overflow=0.
6. Assert resetn=0 mid-group after two beats -> all outputs 0 asynchronously. After release, beat (1,1,ilast) -> result=4, not including pre-reset beats.
